mac_acc12: RTL and testbench
============================

# mac_acc12

Downstream accumulate stage of the 12-bit signed MAC datapath. Accepts a stream of 12-bit two's-complement products over a valid/ready handshake and sums a fixed number of terms per frame with saturating arithmetic. Uses the team's 12-bit signed saturating adder, `sadd12x12`, as its combinational adder. Presents each finished frame sum on a registered valid/ready output with a sticky saturation flag.

## Interface

- Clock/reset (decided): one clock; reset is asynchronous and active-low.
- `N_TERMS`, default 4: terms summed per frame; legal range is N_TERMS ≥ 1.
- `CNT_W`, default `$clog2(N_TERMS+1)`: width of the term counter.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `clr`, input, 1: synchronous frame abort.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: the block accepts a term this cycle.
- `in_data`, input, 12: signed product term.
- `out_valid`, output, 1: the frame result is valid.
- `out_ready`, input, 1: the consumer takes the result.
- `out_data`, output, 12: signed saturated frame sum.
- `out_sat`, output, 1: saturation occurred in at least one add of this frame.

## Operation

- The FSM has two states, ACC and DONE. Reset state is ACC.
- The block holds three registers: `acc[11:0]`, `cnt[CNT_W-1:0]` and `sat`.
- Reset values:
  - acc = 0, cnt = 0, sat = 0.
  - out_valid = 0, out_data = 0, out_sat = 0.
  - in_ready = 1 once rst_n is high.
- `in_ready = (state == ACC)`.
- `out_valid = (state == DONE)`.
- `out_data = acc`.
- `out_sat = sat`.
- ACC state, on a transfer (`in_valid && in_ready`):
  - acc ← `sadd12x12(acc, in_data)`.
  - sat ← sat | ovf, where ovf = (acc[11] == in_data[11]) && ((acc + in_data)[11] != acc[11]), using the 12-bit wrapped sum.
  - cnt ← cnt + 1.
  - If cnt == N_TERMS-1: go to DONE and set cnt ← 0.
- ACC state with no transfer: all registers hold.
- DONE state:
  - acc, sat and cnt hold.
  - in_valid is ignored.
  - When `out_valid && out_ready`: go to ACC and set acc ← 0, sat ← 0.
- Saturation bounds:
  - Positive overflow clamps to +2047 (0x7FF).
  - Negative overflow clamps to −2048 (0x800).
  - Saturation is applied per add and is not associative. Later terms may pull a clamped value back inside the range; `sat` stays set regardless.
- `clr` has priority over every other event in both states. It sets acc ← 0, cnt ← 0, sat ← 0 and state ← ACC, and the input and output transfers in that cycle are discarded.
- Asserting `rst_n` low mid-frame immediately forces the reset values, asynchronously. The partial frame is lost.

## Timing

- Accepted terms are sampled on the rising edge of `clk`.
- out_valid rises in the cycle after the edge that accepts term N_TERMS. Latency is 1 cycle.
- While `out_valid && !out_ready`, out_data and out_sat stay stable and in_ready = 0.
- in_ready returns to 1 in the cycle after the output transfer.
- Peak throughput is one frame per N_TERMS+1 cycles.
- N_TERMS = 1: every accepted term produces a result equal to `in_data`, and out_sat = 0.
- All outputs are decoded from registers, so there is no combinational path from input to output.

## Structure

- Shared package `mac_pkg` holds:
  - `MAC_W = 12`.
  - `SAT_POS = 12'h7FF` and `SAT_NEG = 12'h800`.
  - The state enum {ACC, DONE}.
- Sub-module: one instance of `sadd12x12`, with a ← acc, b ← in_data and sum → acc_next.
- The ovf flag is computed locally from the 12-bit wrapped sum.

## Test plan

- **Plain frame.** N=4, terms 100, −30, 5, 25, out_ready = 1. Expect out_data = 100 (0x064), out_sat = 0. out_valid is high for exactly 1 cycle, one cycle after the 4th accept.
- **Positive clamp.** Terms 2000, 100, −50, 0. Expect the intermediate value to clamp to 2047, then out_data = 1997 (0x7CD), out_sat = 1.
- **Negative clamp.** Terms −2000, −100, 0, 0. Expect out_data = −2048 (0x800), out_sat = 1.
- **Backpressure.**
  - Hold out_ready = 0 for 5 cycles with in_valid = 1 and in_data = 7. Expect out_valid, out_data and out_sat stable, in_ready = 0, and no term absorbed.
  - Release out_ready. The next frame of 1, 1, 1, 1 gives 4 with out_sat = 0.
- **Clear.**
  - Pulse clr after 2 terms, then send 1, 2, 3, 4. Expect out_data = 10.
  - Pulse clr while in DONE. Expect out_valid = 0 on the next cycle with no transfer.
- **Async reset.** Drop rst_n mid-cycle after 3 terms. Expect all outputs at their reset values immediately. After release, a fresh frame of 5, 5, 5, 5 gives 20.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the 12-bit signed MAC datapath.
package mac_pkg;

    localparam int unsigned MAC_W = 12;

    localparam logic [MAC_W-1:0] SAT_POS = 12'h7FF;
    localparam logic [MAC_W-1:0] SAT_NEG = 12'h800;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

endpackage

// File: rtl/sadd12x12.sv
// 12-bit signed saturating adder (combinational).
module sadd12x12
    import mac_pkg::*;
(
    input  logic [MAC_W-1:0] a,
    input  logic [MAC_W-1:0] b,
    output logic [MAC_W-1:0] sum
);

    logic [MAC_W-1:0] wrap;
    logic             pos_ovf;
    logic             neg_ovf;

    // Wrapped add, then clamp when both operands share a sign the result lost.
    always_comb begin
        wrap    = a + b;
        pos_ovf = !a[MAC_W-1] && !b[MAC_W-1] &&  wrap[MAC_W-1];
        neg_ovf =  a[MAC_W-1] &&  b[MAC_W-1] && !wrap[MAC_W-1];
        sum     = wrap;
        if (pos_ovf) begin
            sum = SAT_POS;
        end else if (neg_ovf) begin
            sum = SAT_NEG;
        end
    end

endmodule

// File: rtl/mac_acc12.sv
// Frame accumulator: sums N_TERMS signed terms with per-add saturation.
module mac_acc12
    import mac_pkg::*;
#(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned CNT_W   = $clog2(N_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAC_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAC_W-1:0] out_data,
    output logic             out_sat
);

    state_t           state;
    state_t           state_next;
    logic [MAC_W-1:0] acc;
    logic [MAC_W-1:0] acc_next;
    logic [MAC_W-1:0] wrap;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic             ovf;
    logic             in_xfer;
    logic             out_xfer;
    logic             last;

    sadd12x12 u_sadd (
        .a   (acc),
        .b   (in_data),
        .sum (acc_next)
    );

    // Transfer qualifiers and the local overflow flag from the wrapped sum.
    always_comb begin
        in_xfer  = (state == ACC) && in_valid;
        out_xfer = (state == DONE) && out_ready;
        last     = (cnt == CNT_W'(N_TERMS - 1));
        wrap     = acc + in_data;
        ovf      = (acc[MAC_W-1] == in_data[MAC_W-1]) && (wrap[MAC_W-1] != acc[MAC_W-1]);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clr overrides both transfers.
    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = ACC;
        end else begin
            case (state)
                ACC:     if (in_xfer && last) state_next = DONE;
                DONE:    if (out_xfer)        state_next = ACC;
                default: state_next = ACC;
            endcase
        end
    end

    // Accumulator, term counter and sticky saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (in_xfer) begin
            acc <= acc_next;
            sat <= sat | ovf;
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end else if (out_xfer) begin
            acc <= '0;
            sat <= 1'b0;
        end
    end

    // Outputs decoded directly from registers.
    always_comb begin
        in_ready  = (state == ACC);
        out_valid = (state == DONE);
        out_data  = acc;
        out_sat   = sat;
    end

endmodule

// File: tb/tb_mac_acc12.sv
// Self-checking bench for mac_acc12 against a saturating frame-sum model.
module tb_mac_acc12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_sat;

    logic        in_valid1;
    logic        in_ready1;
    logic [11:0] in_data1;
    logic        out_valid1;
    logic        out_ready1;
    logic [11:0] out_data1;
    logic        out_sat1;
    logic        clr1;

    int vectors = 0;
    int miscompares = 0;

    mac_acc12 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    mac_acc12 #(.N_TERMS(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .out_sat   (out_sat1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: integer running sum, clamped after every add.
    function automatic void model(input logic [11:0] q[$], output logic [11:0] s, output logic sat);
        int a;
        a = 0;
        sat = 1'b0;
        foreach (q[i]) begin
            a = a + int'($signed(q[i]));
            if (a > 2047) begin
                a = 2047;
                sat = 1'b1;
            end else if (a < -2048) begin
                a = -2048;
                sat = 1'b1;
            end
        end
        s = 12'(a);
    endfunction

    // Present one term for one cycle; entered and left at a falling edge.
    task automatic push(input logic [11:0] t);
        in_valid = 1'b1;
        in_data  = t;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1; clr1 = 1'b0;
        #12;
        vectors++;
        if ({in_ready, out_valid, out_sat, out_data} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
            miscompares++;
            $display("FAIL reset_hold: got rdy/vld/sat/data %b%b%b %h, want 100 000", in_ready, out_valid, out_sat, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, out_sat, out_data} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
            miscompares++;
            $display("FAIL reset_release: got rdy/vld/sat/data %b%b%b %h, want 100 000", in_ready, out_valid, out_sat, out_data);
        end
    endtask

    task automatic test_plain();
        push(12'd100); push(-12'sd30); push(12'd5);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL plain_early: out_valid got %b want 0", out_valid);
        end
        push(12'd25);
        vectors++;
        if ({out_valid, out_sat, out_data} !== {1'b1, 1'b0, 12'h064}) begin
            miscompares++;
            $display("FAIL plain_result: got vld/sat/data %b%b %h want 10 064", out_valid, out_sat, out_data);
        end
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL plain_one_cycle: got vld/rdy %b%b want 01", out_valid, in_ready);
        end
    endtask

    task automatic test_pos_clamp();
        push(12'd2000); push(12'd100);
        vectors++;
        if ({out_sat, out_data} !== {1'b1, 12'h7FF}) begin
            miscompares++;
            $display("FAIL pos_clamp_mid: got sat/data %b %h want 1 7ff", out_sat, out_data);
        end
        push(-12'sd50); push(12'd0);
        vectors++;
        if ({out_valid, out_sat, out_data} !== {1'b1, 1'b1, 12'h7CD}) begin
            miscompares++;
            $display("FAIL pos_clamp: got vld/sat/data %b%b %h want 11 7cd", out_valid, out_sat, out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_neg_clamp();
        push(-12'sd2000); push(-12'sd100); push(12'd0); push(12'd0);
        vectors++;
        if ({out_valid, out_sat, out_data} !== {1'b1, 1'b1, 12'h800}) begin
            miscompares++;
            $display("FAIL neg_clamp: got vld/sat/data %b%b %h want 11 800", out_valid, out_sat, out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        push(12'd9); push(12'd8); push(12'd7); push(12'd6);
        in_valid = 1'b1;
        in_data  = 12'd7;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({out_valid, in_ready, out_sat, out_data} !== {1'b1, 1'b0, 1'b0, 12'd30}) begin
                miscompares++;
                $display("FAIL backpressure_hold[%0d]: got vld/rdy/sat/data %b%b%b %h want 100 01e", i, out_valid, in_ready, out_sat, out_data);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL backpressure_release: got vld/rdy %b%b want 01", out_valid, in_ready);
        end
        push(12'd1); push(12'd1); push(12'd1); push(12'd1);
        vectors++;
        if ({out_valid, out_sat, out_data} !== {1'b1, 1'b0, 12'd4}) begin
            miscompares++;
            $display("FAIL backpressure_next: got vld/sat/data %b%b %h want 10 004", out_valid, out_sat, out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_clear();
        push(12'd2000); push(12'd500);
        clr = 1'b1; in_valid = 1'b1; in_data = 12'd99;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        push(12'd1); push(12'd2); push(12'd3);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_count: out_valid got %b want 0", out_valid);
        end
        push(12'd4);
        vectors++;
        if ({out_valid, out_sat, out_data} !== {1'b1, 1'b0, 12'd10}) begin
            miscompares++;
            $display("FAIL clear_frame: got vld/sat/data %b%b %h want 10 00a", out_valid, out_sat, out_data);
        end
        @(negedge clk);
        out_ready = 1'b0;
        push(12'd2000); push(12'd2000); push(12'd1); push(12'd1);
        clr = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        vectors++;
        if ({out_valid, in_ready, out_sat, out_data} !== {1'b0, 1'b1, 1'b0, 12'h000}) begin
            miscompares++;
            $display("FAIL clear_done: got vld/rdy/sat/data %b%b%b %h want 010 000", out_valid, in_ready, out_sat, out_data);
        end
        push(12'd3); push(12'd3); push(12'd3); push(12'd3);
        vectors++;
        if ({out_valid, out_sat, out_data} !== {1'b1, 1'b0, 12'd12}) begin
            miscompares++;
            $display("FAIL clear_after: got vld/sat/data %b%b %h want 10 00c", out_valid, out_sat, out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        push(12'd2000); push(12'd100); push(-12'sd5);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, out_sat, out_data} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
            miscompares++;
            $display("FAIL async_reset: got rdy/vld/sat/data %b%b%b %h want 100 000", in_ready, out_valid, out_sat, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(12'd5); push(12'd5); push(12'd5);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_count: out_valid got %b want 0", out_valid);
        end
        push(12'd5);
        vectors++;
        if ({out_valid, out_sat, out_data} !== {1'b1, 1'b0, 12'd20}) begin
            miscompares++;
            $display("FAIL async_fresh: got vld/sat/data %b%b %h want 10 014", out_valid, out_sat, out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [11:0] q[$];
        logic [11:0] t;
        logic [11:0] exp_s;
        logic        exp_sat;
        int          hold;
        for (int f = 0; f < 40; f++) begin
            q.delete();
            out_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
                int gap;
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) begin
                    in_data = 12'($urandom);
                    @(negedge clk);
                end
                t = ($urandom_range(0, 1) == 0) ? 12'($urandom) : 12'($urandom_range(0, 200) - 100);
                q.push_back(t);
                push(t);
            end
            model(q, exp_s, exp_sat);
            hold = int'($urandom_range(0, 3));
            in_valid = ($urandom_range(0, 1) == 1);
            for (int h = 0; h <= hold; h++) begin
                vectors++;
                if ({out_valid, in_ready, out_sat, out_data} !== {1'b1, 1'b0, exp_sat, exp_s}) begin
                    miscompares++;
                    $display("FAIL random_frame[%0d]: got vld/rdy/sat/data %b%b%b %h want 10%b %h", f, out_valid, in_ready, out_sat, out_data, exp_sat, exp_s);
                end
                if (h == hold) out_ready = 1'b1;
                @(negedge clk);
            end
            in_valid = 1'b0;
            vectors++;
            if ({out_valid, in_ready} !== 2'b01) begin
                miscompares++;
                $display("FAIL random_release[%0d]: got vld/rdy %b%b want 01", f, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_single_term();
        logic [11:0] t;
        for (int i = 0; i < 8; i++) begin
            t = (i == 0) ? 12'h7FF : (i == 1) ? 12'h800 : 12'($urandom);
            in_valid1 = 1'b1;
            in_data1  = t;
            @(negedge clk);
            in_valid1 = 1'b0;
            vectors++;
            if ({out_valid1, in_ready1, out_sat1, out_data1} !== {1'b1, 1'b0, 1'b0, t}) begin
                miscompares++;
                $display("FAIL single_term[%0d]: got vld/rdy/sat/data %b%b%b %h want 100 %h", i, out_valid1, in_ready1, out_sat1, out_data1, t);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_plain();
        test_pos_clamp();
        test_neg_clamp();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_random();
        test_single_term();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
